// File: rtl/brisc_rf_pkg.sv
`default_nettype none
// ============================================================================
// brisc_rf_pkg : shared types and sizing helpers for the brisc register file
// Rev 1.0
// ============================================================================
package brisc_rf_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_e;

    // Address width needed to index n registers
    function automatic int aw_f(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file_sb_if.sv
`default_nettype none
// ============================================================================
// reg_file_sb_if : issue/writeback/read bundle of the brisc register file
// Rev 1.0
// ============================================================================
interface reg_file_sb_if
    import brisc_rf_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NREAD = 2
) ();
    localparam int AW = aw_f(NREGS);

    logic                    ready;
    logic                    w_en;
    logic [AW-1:0]           w_addr;
    logic [XLEN-1:0]         w_data;
    logic                    rsv_en;
    logic [AW-1:0]           rsv_addr;
    logic [NREAD*AW-1:0]     rd_addr;
    logic [NREAD*XLEN-1:0]   rd_data;
    logic [NREAD-1:0]        rd_busy;
    logic                    busy_any;

    modport master (
        output w_en, w_addr, w_data, rsv_en, rsv_addr, rd_addr,
        input  ready, rd_data, rd_busy, busy_any
    );

    modport slave (
        input  w_en, w_addr, w_data, rsv_en, rsv_addr, rd_addr,
        output ready, rd_data, rd_busy, busy_any
    );

endinterface
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// reg_scoreboard : per-register busy bits; reservation beats same-edge release
// Rev 1.0
// ============================================================================
module reg_scoreboard #(
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             set_en,
    input  wire logic [AW-1:0]    set_addr,
    input  wire logic             clr_en,
    input  wire logic [AW-1:0]    clr_addr,
    output logic      [NREGS-1:0] busy,
    output logic                  busy_any
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Set is applied last: a reservation belongs to a newer producer
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_addr] = 1'b0;
        end
        if (set_en) begin
            busy_d[set_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign busy_any = |busy_q;

endmodule
`default_nettype wire

// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
// reg_file_sb : multi-port register file with busy scoreboard and write bypass
// Rev 1.0
// ============================================================================
module reg_file_sb
    import brisc_rf_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NREAD  = 2,
    parameter int BYPASS = 1
) (
    input  wire logic       clk,
    input  wire logic       rst,
    reg_file_sb_if.slave    bus
);

    localparam int AW = aw_f(NREGS);

    rf_state_e        state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic             ready_q, ready_d;

    logic             w_run;
    logic             w_we;
    logic [AW-1:0]    w_wa;
    logic [XLEN-1:0]  w_wd;
    logic [NREGS-1:0] w_busy;

    logic [XLEN-1:0]  mem_q [NREGS];

    assign w_run = (state_q == RUN);

    // The sweep and writeback share the single array write port
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ready_d = ready_q;
        w_we    = 1'b0;
        w_wa    = bus.w_addr;
        w_wd    = bus.w_data;
        case (state_q)
            CLEAR: begin
                w_we  = 1'b1;
                w_wa  = idx_q;
                w_wd  = '0;
                idx_d = idx_q + 1'b1;
                if (idx_q == AW'(NREGS - 1)) begin
                    state_d = RUN;
                    ready_d = 1'b1;
                end
            end
            RUN: begin
                w_we = bus.w_en && (bus.w_addr != '0);
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            idx_q   <= AW'(1);
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ready_q <= ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we && !rst) begin
            mem_q[w_wa] <= w_wd;
        end
    end

    reg_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (w_run && bus.rsv_en && (bus.rsv_addr != '0)),
        .set_addr (bus.rsv_addr),
        .clr_en   (w_run && bus.w_en && (bus.w_addr != '0)),
        .clr_addr (bus.w_addr),
        .busy     (w_busy),
        .busy_any (bus.busy_any)
    );

    assign bus.ready = ready_q;

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [AW-1:0] w_rd_addr;
        logic          w_hit;
        logic          w_zero;

        assign w_rd_addr = bus.rd_addr[k*AW +: AW];
        assign w_zero    = !w_run || (w_rd_addr == '0);
        assign w_hit     = (BYPASS != 0) && bus.w_en && (bus.w_addr == w_rd_addr);

        assign bus.rd_data[k*XLEN +: XLEN] = w_zero ? '0 :
                                             w_hit  ? bus.w_data :
                                                      mem_q[w_rd_addr];
        assign bus.rd_busy[k] = !w_zero && !w_hit && w_busy[w_rd_addr];
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// ============================================================================
// tb_reg_file_sb : scoreboard bench driving a bypass and a no-bypass instance
// Rev 1.0
// ============================================================================
module tb_reg_file_sb;

    logic        clk;
    logic        rst;
    logic        s_w_en;
    logic [4:0]  s_w_addr;
    logic [31:0] s_w_data;
    logic        s_rsv_en;
    logic [4:0]  s_rsv_addr;
    logic [4:0]  s_a0;
    logic [4:0]  s_a1;

    int n_checks;
    int n_fail;

    logic [31:0] m_reg  [32];
    logic [31:0] m_busy;

    logic [63:0] exp_q [$];
    int          sel_q [$];

    reg_file_sb_if #(.XLEN(32), .NREGS(32), .NREAD(2)) bus_a ();
    reg_file_sb_if #(.XLEN(32), .NREGS(32), .NREAD(2)) bus_b ();

    assign bus_a.w_en     = s_w_en;
    assign bus_a.w_addr   = s_w_addr;
    assign bus_a.w_data   = s_w_data;
    assign bus_a.rsv_en   = s_rsv_en;
    assign bus_a.rsv_addr = s_rsv_addr;
    assign bus_a.rd_addr  = {s_a1, s_a0};
    assign bus_b.w_en     = s_w_en;
    assign bus_b.w_addr   = s_w_addr;
    assign bus_b.w_data   = s_w_data;
    assign bus_b.rsv_en   = s_rsv_en;
    assign bus_b.rsv_addr = s_rsv_addr;
    assign bus_b.rd_addr  = {s_a1, s_a0};

    reg_file_sb #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(1)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    reg_file_sb #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(0)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // sel: 0-3 data (dut*2+port), 4-7 busy (4+dut*2+port), 8/9 busy_any a/b
    function automatic logic [63:0] observe(input int sel);
        case (sel)
            0: return {32'h0, bus_a.rd_data[31:0]};
            1: return {32'h0, bus_a.rd_data[63:32]};
            2: return {32'h0, bus_b.rd_data[31:0]};
            3: return {32'h0, bus_b.rd_data[63:32]};
            4: return {63'h0, bus_a.rd_busy[0]};
            5: return {63'h0, bus_a.rd_busy[1]};
            6: return {63'h0, bus_b.rd_busy[0]};
            7: return {63'h0, bus_b.rd_busy[1]};
            8: return {63'h0, bus_a.busy_any};
            9: return {63'h0, bus_b.busy_any};
            default: return 64'h0;
        endcase
    endfunction

    task automatic drain(input string tag);
        int          sel;
        logic [63:0] exp;
        while (exp_q.size() > 0) begin
            sel = sel_q.pop_front();
            exp = exp_q.pop_front();
            chk($sformatf("%s_s%0d", tag, sel), observe(sel), exp);
        end
    endtask

    task automatic idle_inputs();
        s_w_en     = 1'b0;
        s_w_addr   = 5'd0;
        s_w_data   = 32'h0;
        s_rsv_en   = 1'b0;
        s_rsv_addr = 5'd0;
        s_a0       = 5'd0;
        s_a1       = 5'd0;
    endtask

    // One RUN cycle: drive, predict reads from the model, compare, then advance the model
    task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic re, input logic [4:0] ra,
                        input logic [4:0] a0, input logic [4:0] a1, input string tag);
        logic [4:0]  a;
        logic        hit;
        logic [31:0] ed;
        logic        eb;
        @(negedge clk);
        s_w_en = we; s_w_addr = wa; s_w_data = wd;
        s_rsv_en = re; s_rsv_addr = ra;
        s_a0 = a0; s_a1 = a1;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                a   = (p == 1) ? a1 : a0;
                hit = (d == 0) && we && (wa == a);
                ed  = (a == 5'd0) ? 32'h0 : (hit ? wd : m_reg[a]);
                eb  = (a == 5'd0 || hit) ? 1'b0 : m_busy[a];
                sel_q.push_back(d * 2 + p);
                exp_q.push_back({32'h0, ed});
                sel_q.push_back(4 + d * 2 + p);
                exp_q.push_back({63'h0, eb});
            end
            sel_q.push_back(8 + d);
            exp_q.push_back({63'h0, |m_busy});
        end
        #2;
        drain(tag);
        if (we && wa != 5'd0) begin
            m_reg[wa]  = wd;
            m_busy[wa] = 1'b0;
        end
        if (re && ra != 5'd0) begin
            m_busy[ra] = 1'b1;
        end
    endtask

    // Reset for hold cycles; abort>0 re-pulses rst after that many sweep edges
    task automatic do_reset(input int hold, input int abort, input string tag);
        int n;
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        s_a0 = 5'd4; s_a1 = 5'd31;
        repeat (hold) @(negedge clk);
        chk({tag, "_rst_ready"}, {63'h0, bus_a.ready}, 64'h0);
        chk({tag, "_rst_bany"}, {63'h0, bus_a.busy_any}, 64'h0);
        chk({tag, "_rst_rd"}, {32'h0, bus_a.rd_data[31:0]}, 64'h0);
        chk({tag, "_rst_rbusy"}, {62'h0, bus_a.rd_busy}, 64'h0);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
        m_busy = 32'h0;
        if (abort > 0) begin
            repeat (abort) @(posedge clk);
            #1;
            chk({tag, "_mid_ready"}, {63'h0, bus_a.ready}, 64'h0);
            @(negedge clk);
            rst = 1'b1;
            @(posedge clk);
            #1;
            chk({tag, "_mid_bany"}, {63'h0, bus_a.busy_any}, 64'h0);
            @(negedge clk);
            rst = 1'b0;
        end
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (n == 5) begin
                chk({tag, "_sweep_rd"}, {bus_a.rd_data}, 64'h0);
            end
        end while (!bus_a.ready && n < 100);
        chk({tag, "_ready_lat_a"}, 64'(n), 64'd31);
        chk({tag, "_ready_b"}, {63'h0, bus_b.ready}, 64'h1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        idle_inputs();
        for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
        m_busy = 32'h0;

        do_reset(3, 0, "t1");
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd31, "t1_rd");

        step(1'b1, 5'd1, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 5'd0, "t2_wr");
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd1, 5'd1, "t2_rd");

        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd0, 5'd0, "t3_rsv");
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd1, "t3_busy");
        step(1'b1, 5'd3, 32'hFEEDFEED, 1'b0, 5'd0, 5'd3, 5'd3, "t3_byp");
        #4;
        chk("t3_bany_after", {63'h0, bus_a.busy_any}, 64'h0);

        step(1'b1, 5'd7, 32'h00005555, 1'b0, 5'd0, 5'd0, 5'd0, "t4_pre");
        step(1'b1, 5'd7, 32'h00001234, 1'b1, 5'd7, 5'd7, 5'd7, "t4_same");
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7, "t4_after");

        step(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd0, "t5_x0");
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd7, "t5_rd");

        for (int i = 0; i < 24; i++) begin
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), "rnd");
        end

        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 5'd0, 5'd0, "t6_rsv");
        step(1'b1, 5'd4, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd4, 5'd2, "t6_wr");
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd2, "t6_pre");
        do_reset(1, 9, "t6");
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd2, "t6_rd");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised register file: generalised width, depth and read-port count, plus a per-register busy-bit scoreboard and an optional write-to-read bypass. Sits between decode/issue and writeback in the brisc core.
- Issue reserves the destination register.
- Writeback writes the data and releases the reservation.
- Reset clears storage by a sequential sweep, so the array can map to FPGA block/distributed RAM.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of two, >=4); register 0 hard-wired to zero
NREAD, 2, number of independent read ports
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads see array contents only
AW, $clog2(NREGS), address width (derived, not overridden)

Ports:
clk  in  1  clock, rising-edge
rst  in  1  reset, synchronous, active-high
ready  out  1  high when the reset sweep is done and ports are live
w_en  in  1  writeback enable
w_addr  in  AW  writeback register
w_data  in  XLEN  writeback data
rsv_en  in  1  reserve (mark busy) enable
rsv_addr  in  AW  register to reserve
rd_addr  in  NREAD*AW  read addresses; port k uses bits [k*AW +: AW]
rd_data  out  NREAD*XLEN  read data; port k uses bits [k*XLEN +: XLEN]
rd_busy  out  NREAD  port k: addressed register has a pending producer
busy_any  out  1  OR of all busy bits

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high. All state changes on the rising edge of clk.
- FSM states CLEAR and RUN.
- While rst=1:
  - state<=CLEAR, sweep index<=1, all busy bits<=0.
  - ready=0, busy_any=0, rd_busy=0, rd_data=0.
- CLEAR (rst=0):
  - Each cycle writes 0 to register[index], then index+1.
  - When index==NREGS-1 the write completes and state<=RUN.
  - ready rises exactly NREGS-1 edges after the first rst=0 edge.
  - w_en and rsv_en are ignored.
  - rd_data and rd_busy are forced to 0.
- rst asserted mid-sweep or mid-RUN: restart from CLEAR, index 1, busy cleared. Pending reservations are lost.
- RUN reads (combinational, zero latency):
  - rd_data[k] = 0 if addr==0.
  - Otherwise, if BYPASS && w_en && w_addr==addr, rd_data[k] = w_data.
  - Otherwise rd_data[k] = register[addr].
- rd_busy[k] = busy[addr], except 0 if addr==0 or (BYPASS && w_en && w_addr==addr).
- RUN writes: if w_en && w_addr!=0, register[w_addr]<=w_data and busy[w_addr]<=0 at the edge.
- RUN reserves: if rsv_en && rsv_addr!=0, busy[rsv_addr]<=1.
- Simultaneous w_en and rsv_en to the same register:
  - data is written and busy ends 1, because the reservation belongs to a newer producer and wins.
  - Same-cycle rd_busy for that address still follows the bypass rule above.
- Write to a non-busy register is legal: data written, busy stays 0.
- Reserve of an already-busy register is legal: busy stays 1.
- Writes and reserves to register 0 are silently dropped. Register 0 is never stored and never busy.
- busy_any is registered-state derived (OR of busy vector), with no bypass term.
- Any number of read ports may address the same register; each port is independent.

Decomposition:
- Package brisc_rf_pkg:
  - state enum {CLEAR, RUN}
  - function for AW derivation
  - default XLEN/NREGS localparams shared with decode/writeback
- Sub-module reg_scoreboard (NREGS, AW): owns the busy vector, set/clear priority, clear on rst, busy_any output. reg_file_sb instantiates it plus the storage array, sweep FSM and read muxes.

Test Plan:
1. Reset sweep: rst=1 for 3 cycles, then 0. ready=0 for exactly 31 edges, then 1; reading x5 and x31 returns 0x00000000.
2. Basic write/read: w_en, w_addr=1, w_data=0xDEADBEEF, then read x1 on ports 0 and 1 next cycle. Both return 0xDEADBEEF; rd_busy=0.
3. Scoreboard: rsv x3, next cycle read x3 gives rd_busy=1. Write x3=0xFEEDFEED: same cycle rd_data=0xFEEDFEED, rd_busy=0 (BYPASS=1); after the edge busy_any=0.
4. Same-cycle reserve and write x7=0x1234: next cycle rd_data=0x1234, rd_busy=1, busy_any=1. Rerun with BYPASS=0: same-cycle read returns old x7 value.
5. x0 handling: w_en to x0 with 0xFFFFFFFF, rsv x0. Reads of x0 return 0, rd_busy=0, busy_any unchanged.
6. Mid-op reset: reserve x2, write x4=0xA5A5A5A5, pulse rst at sweep index 10. busy_any=0; ready low for 31 edges; x4 reads 0 afterwards.
